// File: rtl/gate_exerciser_4.sv
// Purpose : 4-gate (2-input) quad exerciser; walks 16 vectors over A/B, checks Y against GATE_FN, reports PASS/FAIL_CNT/FAIL_IDX.
// Latency : START at edge k -> DONE after edge k+16*(SETTLE+1); k+16*(SETTLE+3) with the Y synchronizer built in.
// Backpress: none; START is accepted only in IDLE/FIN and ignored while BUSY.
//
// Ports:
//   CLK, CLR_N (async active-low), START    : clock, reset, run request
//   A[3:0], B[3:0] -> device, Y[3:0] <- device : bit 3 = gate 1 ... bit 0 = gate 4
//   BUSY, DONE, PASS, FAIL_CNT[4:0], FAIL_IDX[3:0] : run status and results
// Build option: define GATE_EXERCISER_SYNC_Y_EN to pass Y through a 2-flop
// synchronizer before comparison (each vector then takes SETTLE+3 cycles).

module gate_exerciser_4 #(
    parameter int SETTLE  = 2,  // wait cycles per vector, 1..15
    parameter int GATE_FN = 0   // 0 OR, 1 AND, 2 NAND, 3 NOR, 4 XOR
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       START,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic [3:0] Y,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [4:0] FAIL_CNT,
    output logic [3:0] FAIL_IDX
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_FIN   = 2'd3
    } state_t;

`ifdef GATE_EXERCISER_SYNC_Y_EN
    // Two extra wait cycles cover the synchronizer delay so CHECK sees the
    // settled response of the current vector.
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam logic [4:0] CNT_LOAD = 5'(SETTLE + EXTRA);

    state_t     state, state_nx;
    logic [3:0] idx, idx_nx;
    logic [4:0] cnt, cnt_nx;
    logic [3:0] a_nx, b_nx;
    logic       busy_nx, done_nx, pass_nx;
    logic [4:0] fail_cnt_nx;
    logic [3:0] fail_idx_nx;
    logic [3:0] y_cmp;
    logic [3:0] y_exp;
    logic       mismatch;
    logic [4:0] fail_cnt_upd;

`ifdef GATE_EXERCISER_SYNC_Y_EN
    logic [3:0] y_s1, y_s2;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            y_s1 <= '0;
            y_s2 <= '0;
        end else begin
            y_s1 <= Y;
            y_s2 <= y_s1;
        end
    end

    assign y_cmp = y_s2;
`else
    assign y_cmp = Y;
`endif

    // Vector i exercises gate i/4 (bit 3-i/4, i.e. ~i[3:2]) with combo i%4:
    // (A,B) = (1,1),(0,1),(1,0),(0,0) -> A bit = ~i[0], B bit = ~i[1].
    function automatic logic [3:0] vec_a(input logic [3:0] i);
        logic [3:0] v;
        v = '0;
        v[~i[3:2]] = ~i[0];
        return v;
    endfunction

    function automatic logic [3:0] vec_b(input logic [3:0] i);
        logic [3:0] v;
        v = '0;
        v[~i[3:2]] = ~i[1];
        return v;
    endfunction

    // Expected response applies the gate to all four bits, so idle bits of
    // inverting gates (NAND/NOR) are expected high.
    function automatic logic [3:0] gate_expect(input logic [3:0] a, input logic [3:0] b);
        case (GATE_FN)
            0:       return a | b;
            1:       return a & b;
            2:       return ~(a & b);
            3:       return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    assign y_exp        = gate_expect(A, B);
    assign mismatch     = (y_cmp != y_exp);
    // Saturate at 16 so the count never wraps.
    assign fail_cnt_upd = (mismatch && FAIL_CNT != 5'd16) ? FAIL_CNT + 5'd1 : FAIL_CNT;

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        cnt_nx      = cnt;
        a_nx        = A;
        b_nx        = B;
        busy_nx     = BUSY;
        done_nx     = DONE;
        pass_nx     = PASS;
        fail_cnt_nx = FAIL_CNT;
        fail_idx_nx = FAIL_IDX;

        case (state)
            S_IDLE, S_FIN: begin
                if (START) begin
                    idx_nx      = 4'd0;
                    fail_cnt_nx = 5'd0;
                    fail_idx_nx = 4'd0;
                    pass_nx     = 1'b0;
                    done_nx     = 1'b0;
                    a_nx        = vec_a(4'd0);
                    b_nx        = vec_b(4'd0);
                    cnt_nx      = CNT_LOAD;
                    busy_nx     = 1'b1;
                    state_nx    = S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_nx = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    state_nx = S_CHECK;
                end
            end

            S_CHECK: begin
                fail_cnt_nx = fail_cnt_upd;
                if (mismatch && FAIL_CNT == 5'd0) begin
                    fail_idx_nx = idx;
                end
                if (idx != 4'd15) begin
                    idx_nx   = idx + 4'd1;
                    a_nx     = vec_a(idx + 4'd1);
                    b_nx     = vec_b(idx + 4'd1);
                    cnt_nx   = CNT_LOAD;
                    state_nx = S_WAIT;
                end else begin
                    a_nx     = 4'd0;
                    b_nx     = 4'd0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    pass_nx  = (fail_cnt_upd == 5'd0);
                    state_nx = S_FIN;
                end
            end

            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            A        <= '0;
            B        <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            FAIL_CNT <= '0;
            FAIL_IDX <= '0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            cnt      <= cnt_nx;
            A        <= a_nx;
            B        <= b_nx;
            BUSY     <= busy_nx;
            DONE     <= done_nx;
            PASS     <= pass_nx;
            FAIL_CNT <= fail_cnt_nx;
            FAIL_IDX <= fail_idx_nx;
        end
    end

endmodule

// File: tb/tb_gate_exerciser_4.sv
// Purpose : directed bench for gate_exerciser_4 (GATE_FN=0 OR, SETTLE=2, default build).
// Latency : expects DONE after 48 cycles from the START edge.
// Backpress: n/a; the device model on Y responds combinationally to A/B.

module tb_gate_exerciser_4;

    logic       clk;
    logic       clr_n;
    logic       start;
    logic [3:0] a, b, y;
    logic       busy, done, pass;
    logic [4:0] fail_cnt;
    logic [3:0] fail_idx;

    // 0 = ideal OR, 1 = bit 1 stuck at 0, 2 = forced 4'b1111
    int model;

    int checks = 0;
    int errors = 0;

    gate_exerciser_4 #(.SETTLE(2), .GATE_FN(0)) dut (
        .CLK      (clk),
        .CLR_N    (clr_n),
        .START    (start),
        .A        (a),
        .B        (b),
        .Y        (y),
        .BUSY     (busy),
        .DONE     (done),
        .PASS     (pass),
        .FAIL_CNT (fail_cnt),
        .FAIL_IDX (fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (model)
            0:       y = a | b;
            1:       y = (a | b) & 4'b1101;
            default: y = 4'b1111;
        endcase
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // START high for exactly one rising edge; returns at the negedge after it.
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_fcnt"}, fail_cnt, 0);
        chk({tag, "_fidx"}, fail_idx, 0);
    endtask

    // Counts cycles with BUSY high, bounded so a stuck DUT cannot hang the run.
    task automatic run_to_done(input string tag, input int exp_busy);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            chk({tag, "_pass_while_busy"}, pass, 0);
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, n, exp_busy);
    endtask

    initial begin
        model = 0;
        start = 1'b0;
        clr_n = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Ideal OR: 48 busy cycles, clean pass.
        start_pulse();
        chk("t1_busy_after_start", busy, 1);
        chk("t1_a_vec0", a, 4'b1000);
        chk("t1_b_vec0", b, 4'b1000);
        repeat (3) @(negedge clk);
        chk("t1_a_vec1", a, 4'b0000);
        chk("t1_b_vec1", b, 4'b1000);
        run_to_done("t1", 45);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_fcnt", fail_cnt, 0);
        chk("t1_fidx", fail_idx, 0);
        chk("t1_a_idle", a, 0);
        repeat (3) @(negedge clk);
        chk("t1_hold_done", done, 1);
        chk("t1_hold_pass", pass, 1);

        // Gate 3 output stuck low: vectors 8,9,10 fail.
        model = 1;
        start_pulse();
        chk("t2_done_cleared", done, 0);
        chk("t2_busy", busy, 1);
        run_to_done("t2", 48);
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 0);
        chk("t2_fcnt", fail_cnt, 3);
        chk("t2_fidx", fail_idx, 8);

        // Y forced to 1111: every vector fails.
        model = 2;
        start_pulse();
        run_to_done("t3", 48);
        chk("t3_done", done, 1);
        chk("t3_pass", pass, 0);
        chk("t3_fcnt", fail_cnt, 16);
        chk("t3_fidx", fail_idx, 0);

        // Reset at cycle 20 of a run, then a fresh ideal run.
        model = 0;
        start_pulse();
        repeat (19) @(negedge clk);
        chk("t4_busy_mid", busy, 1);
        clr_n = 1'b0;
        #1;
        chk_all_zero("t4_rst");
        repeat (2) @(negedge clk);
        chk_all_zero("t4_rst_hold");
        clr_n = 1'b1;
        @(negedge clk);
        start_pulse();
        run_to_done("t4", 48);
        chk("t4_done", done, 1);
        chk("t4_pass", pass, 1);
        chk("t4_fcnt", fail_cnt, 0);

        // START pulses mid-run are ignored; DONE still appears at cycle 48.
        begin
            int done_at;
            done_at = -1;
            start_pulse();
            for (int n = 1; n <= 60; n++) begin
                start = (n == 5 || n == 30);
                @(negedge clk);
                if (done_at < 0 && done === 1'b1) done_at = n;
            end
            start = 1'b0;
            chk("t5_done_cycle", done_at, 48);
            chk("t5_pass", pass, 1);
            chk("t5_fcnt", fail_cnt, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
